// File: rtl/comm_rx_packet.sv
// comm_rx_packet: 8N1 UART receiver feeding a length-prefixed packet assembler.
// The first byte of a packet is its payload length L, followed by L payload bytes.
// Completed packets are held on rx_valid/rx_data/rx_len until the consumer accepts them.
// DIVISOR = CLK_HZ/BAUD must be at least 4 so the half-bit start check is meaningful.
module comm_rx_packet #(
   parameter int unsigned CLK_HZ       = 50000000,
   parameter int unsigned BAUD         = 115200,
   parameter int unsigned MAX_BYTES    = 16,
   parameter int unsigned TIMEOUT_BITS = 32
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     rx,
   input  logic                     rx_ready,
   output logic                     rx_valid,
   output logic [8*MAX_BYTES-1:0]   rx_data,
   output logic [7:0]               rx_len,
   output logic                     busy,
   output logic                     err_frame,
   output logic                     err_len,
   output logic                     err_timeout,
   output logic                     err_overrun
);

   localparam int unsigned DIVISOR = CLK_HZ / BAUD;
   localparam int unsigned HALF    = DIVISOR / 2;
   localparam int unsigned TLIM    = TIMEOUT_BITS * DIVISOR;
   localparam int unsigned BCW     = $clog2(DIVISOR + 1);
   localparam int unsigned TCW     = $clog2(TLIM + 1);

   localparam logic [BCW-1:0] DIV_LAST  = BCW'(DIVISOR - 1);
   localparam logic [BCW-1:0] HALF_LAST = BCW'(HALF - 1);
   localparam logic [TCW-1:0] TO_LAST   = TCW'(TLIM - 1);
   localparam logic [7:0]     MAX_LEN   = 8'(MAX_BYTES);

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_e;
   typedef enum logic [1:0] {IDLE, PAYLOAD, DELIVER} pkt_state_e;

   logic           rx_meta;
   logic           rx_sync;

   bit_state_e     bit_state;
   logic [BCW-1:0] bit_cnt;
   logic [2:0]     bit_idx;
   logic [7:0]     shift;
   logic           armed;
   logic           byte_stb;
   logic           frame_evt;
   logic           start_det;

   pkt_state_e     pkt_state;
   logic [7:0]     pkt_len;
   logic [7:0]     pkt_cnt;
   logic [TCW-1:0] to_cnt;
   logic           len_bad;
   logic           to_hit;

   // Two-flop synchroniser; resets high so reset release never looks like a start bit
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
      end
   end

   assign start_det = (bit_state == B_IDLE) && armed && !rx_sync;

   // Bit engine: start qualification, 8 data bits LSB first, stop check, re-arm after frame error
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         bit_state <= B_IDLE;
         bit_cnt   <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         armed     <= 1'b1;
         byte_stb  <= 1'b0;
         frame_evt <= 1'b0;
      end else begin
         byte_stb  <= 1'b0;
         frame_evt <= 1'b0;
         unique case (bit_state)
            B_IDLE: begin
               if (!armed) begin
                  // Need a full bit period of continuous idle-high before trusting the line
                  if (!rx_sync) begin
                     bit_cnt <= '0;
                  end else if (bit_cnt == DIV_LAST) begin
                     bit_cnt <= '0;
                     armed   <= 1'b1;
                  end else begin
                     bit_cnt <= bit_cnt + BCW'(1);
                  end
               end else if (!rx_sync) begin
                  bit_state <= B_START;
                  bit_cnt   <= '0;
               end
            end
            B_START: begin
               if (bit_cnt == HALF_LAST) begin
                  bit_cnt   <= '0;
                  bit_idx   <= '0;
                  bit_state <= rx_sync ? B_IDLE : B_DATA;
               end else begin
                  bit_cnt <= bit_cnt + BCW'(1);
               end
            end
            B_DATA: begin
               if (bit_cnt == DIV_LAST) begin
                  bit_cnt <= '0;
                  shift   <= {rx_sync, shift[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
                     bit_state <= B_STOP;
                  end
               end else begin
                  bit_cnt <= bit_cnt + BCW'(1);
               end
            end
            B_STOP: begin
               if (bit_cnt == DIV_LAST) begin
                  bit_cnt   <= '0;
                  bit_state <= B_IDLE;
                  if (rx_sync) begin
                     byte_stb <= 1'b1;
                  end else begin
                     frame_evt <= 1'b1;
                     armed     <= 1'b0;
                  end
               end else begin
                  bit_cnt <= bit_cnt + BCW'(1);
               end
            end
            default: bit_state <= B_IDLE;
         endcase
      end
   end

   // shift is stable while the strobe is consumed: it only moves again in B_DATA
   assign len_bad = (shift == 8'd0) || (shift > MAX_LEN);
   assign to_hit  = (pkt_state == PAYLOAD) && (to_cnt == TO_LAST);
   assign busy    = !((pkt_state == IDLE) && (bit_state == B_IDLE));

   // Packet FSM: length byte, payload collection, delivery hold, error arbitration
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         pkt_state   <= IDLE;
         pkt_len     <= '0;
         pkt_cnt     <= '0;
         to_cnt      <= '0;
         rx_valid    <= 1'b0;
         rx_data     <= '0;
         rx_len      <= '0;
         err_frame   <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;
      end else begin
         err_frame   <= 1'b0;
         err_len     <= 1'b0;
         err_timeout <= 1'b0;
         err_overrun <= 1'b0;

         if ((pkt_state != PAYLOAD) || start_det) begin
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + TCW'(1);
         end

         // len and timeout live in different states, so each branch's if-chain is the priority
         unique case (pkt_state)
            IDLE: begin
               if (frame_evt) begin
                  err_frame <= 1'b1;
               end else if (byte_stb) begin
                  if (len_bad) begin
                     err_len <= 1'b1;
                  end else begin
                     pkt_len   <= shift;
                     pkt_cnt   <= '0;
                     rx_data   <= '0;
                     pkt_state <= PAYLOAD;
                  end
               end
            end
            PAYLOAD: begin
               if (frame_evt) begin
                  err_frame <= 1'b1;
                  pkt_state <= IDLE;
               end else if (to_hit) begin
                  err_timeout <= 1'b1;
                  pkt_state   <= IDLE;
               end else if (byte_stb) begin
                  // First payload byte goes to the most significant byte lane
                  for (int i = 0; i < int'(MAX_BYTES); i++) begin
                     if (pkt_cnt == 8'(i)) begin
                        rx_data[8*(MAX_BYTES-i)-1 -: 8] <= shift;
                     end
                  end
                  pkt_cnt <= pkt_cnt + 8'd1;
                  if (pkt_cnt == pkt_len - 8'd1) begin
                     rx_len    <= pkt_len;
                     rx_valid  <= 1'b1;
                     pkt_state <= DELIVER;
                  end
               end
            end
            DELIVER: begin
               if (frame_evt) begin
                  err_frame <= 1'b1;
               end else if (byte_stb) begin
                  err_overrun <= 1'b1;
               end
               if (rx_valid && rx_ready) begin
                  rx_valid  <= 1'b0;
                  pkt_state <= IDLE;
               end
            end
            default: pkt_state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_comm_rx_packet.sv
// Bench for comm_rx_packet at DIVISOR=10: directed byte streams, a packet-level model
// scheduled by byte completion times, and a per-cycle compare against that model.
module tb_comm_rx_packet;

   localparam int unsigned MB = 16;

   logic         clk = 1'b0;
   logic         resetn = 1'b0;
   logic         rx = 1'b1;
   logic         rx_ready = 1'b1;
   logic         rx_valid;
   logic [127:0] rx_data;
   logic [7:0]   rx_len;
   logic         busy;
   logic         err_frame;
   logic         err_len;
   logic         err_timeout;
   logic         err_overrun;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   comm_rx_packet #(
      .CLK_HZ      (50000000),
      .BAUD        (5000000),
      .MAX_BYTES   (MB),
      .TIMEOUT_BITS(32)
   ) dut (
      .clk        (clk),
      .resetn     (resetn),
      .rx         (rx),
      .rx_ready   (rx_ready),
      .rx_valid   (rx_valid),
      .rx_data    (rx_data),
      .rx_len     (rx_len),
      .busy       (busy),
      .err_frame  (err_frame),
      .err_len    (err_len),
      .err_timeout(err_timeout),
      .err_overrun(err_overrun)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // A byte whose start bit is driven after edge N starts being received at N+3
   // (two sync flops plus detection) and its outcome is visible after edge N+99.
   typedef struct {
      int         at;
      logic [7:0] val;
      bit         ok;
   } byte_ev_t;

   byte_ev_t byte_q[$];
   int       det_q[$];

   // Packet-level model state
   int           m_mode = 0;       // 0 idle, 1 collecting payload, 2 holding a packet
   int           m_len = 0;
   logic [7:0]   m_bytes[$];
   int           t_ref = 0;        // last timeout restart point
   int           bit_end = 0;      // first cycle the receiver is idle again
   bit           exp_valid = 1'b0;
   logic [7:0]   exp_len = '0;
   logic [127:0] exp_data = '0;
   logic         rdy_prev = 1'b1;

   // Observations used by the hand-computed checks
   int           n_valid = 0;
   int           n_frame = 0;
   int           n_len = 0;
   int           n_timeout = 0;
   int           n_overrun = 0;
   int           to_seen = -1;
   logic [127:0] last_data = '0;
   logic [7:0]   last_len = '0;
   logic         valid_prev = 1'b0;

   always @(negedge clk) begin : compare
      logic [3:0]   exp_err;
      logic [127:0] d;
      bit           old_valid;
      byte_ev_t     ev;
      exp_err = 4'b0000;
      if (!resetn) begin
         m_mode    = 0;
         m_bytes.delete();
         byte_q.delete();
         det_q.delete();
         exp_valid = 1'b0;
         bit_end   = 0;
         check("reset_data", rx_data, 128'd0);
         check("reset_ctrl", {rx_valid, rx_len, busy, err_frame, err_len, err_timeout,
                              err_overrun}, 128'd0);
      end else begin
         old_valid = exp_valid;
         while (det_q.size() > 0 && det_q[0] == cyc) begin
            void'(det_q.pop_front());
            t_ref   = cyc;
            bit_end = cyc + 95;
         end
         if (m_mode == 1 && cyc == t_ref + 320) begin
            exp_err[1] = 1'b1;
            m_mode     = 0;
         end
         while (byte_q.size() > 0 && byte_q[0].at == cyc) begin
            ev = byte_q.pop_front();
            if (!ev.ok) begin
               exp_err = 4'b1000;
               if (m_mode == 1) m_mode = 0;
            end else if (m_mode == 0) begin
               if (ev.val == 8'd0 || ev.val > MB) begin
                  exp_err[2] = 1'b1;
               end else begin
                  m_mode = 1;
                  m_len  = int'(ev.val);
                  m_bytes.delete();
                  t_ref  = cyc;
               end
            end else if (m_mode == 1) begin
               m_bytes.push_back(ev.val);
               if (m_bytes.size() == m_len) begin
                  d = '0;
                  foreach (m_bytes[i]) d[127 - 8*i -: 8] = m_bytes[i];
                  exp_valid = 1'b1;
                  exp_len   = 8'(m_len);
                  exp_data  = d;
                  m_mode    = 2;
               end
            end else begin
               exp_err[0] = 1'b1;
            end
         end
         if (old_valid && rdy_prev) begin
            exp_valid = 1'b0;
            m_mode    = 0;
         end

         check("err_flags", {err_frame, err_len, err_timeout, err_overrun}, exp_err);
         check("busy", busy, (m_mode != 0) || (cyc < bit_end));
         check("rx_valid", rx_valid, exp_valid);
         if (exp_valid) begin
            check("rx_len", rx_len, exp_len);
            check("rx_data", rx_data, exp_data);
         end
      end

      if (rx_valid && !valid_prev) begin
         n_valid++;
         last_data = rx_data;
         last_len  = rx_len;
      end
      valid_prev = rx_valid;
      n_frame   += int'(err_frame);
      n_len     += int'(err_len);
      n_overrun += int'(err_overrun);
      if (err_timeout) begin
         n_timeout++;
         to_seen = cyc;
      end
      rdy_prev = rx_ready;
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called just after a rising edge; drives one 8N1 frame, 10 clocks per bit
   task automatic send_byte(input logic [7:0] b, input bit stop_ok = 1'b1);
      logic [9:0] frame;
      frame = {stop_ok, b, 1'b0};
      det_q.push_back(cyc + 3);
      byte_q.push_back('{at: cyc + 99, val: b, ok: stop_ok});
      for (int i = 0; i < 10; i++) begin
         rx = frame[i];
         tick(10);
      end
      rx = 1'b1;
   endtask

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
      $fatal(1, "watchdog");
   end

   initial begin : stimulus
      int v0;
      int e0;
      int n55;
      resetn   = 1'b0;
      rx       = 1'b1;
      rx_ready = 1'b1;
      tick(3);
      check("reset_busy", busy, 1'b0);
      check("reset_len", rx_len, 8'd0);
      resetn = 1'b1;
      tick(5);

      // Nominal packet
      v0 = n_valid;
      e0 = n_frame + n_len + n_timeout + n_overrun;
      send_byte(8'h04); tick(4);
      send_byte(8'h74); tick(4);
      send_byte(8'hFB); tick(4);
      send_byte(8'h7B); tick(4);
      send_byte(8'hFE); tick(6);
      check("nom_count", n_valid - v0, 1);
      check("nom_len", last_len, 8'd4);
      check("nom_data_hi", last_data[127:96], 32'h74FB7BFE);
      check("nom_data_lo", last_data[95:0], 96'd0);
      check("nom_errs", n_frame + n_len + n_timeout + n_overrun - e0, 0);
      check("nom_single", rx_valid, 1'b0);

      // Bad lengths, then a good one-byte packet
      v0 = n_valid;
      e0 = n_len;
      send_byte(8'h00); tick(4);
      send_byte(8'h11); tick(4);
      check("badlen_novalid", n_valid - v0, 0);
      send_byte(8'h01); tick(4);
      send_byte(8'hAB); tick(6);
      check("badlen_pulses", n_len - e0, 2);
      check("badlen_count", n_valid - v0, 1);
      check("badlen_len", last_len, 8'd1);
      check("badlen_data", last_data[127:120], 8'hAB);

      // Framing error mid-packet, then recovery
      v0 = n_valid;
      e0 = n_frame;
      send_byte(8'h03); tick(4);
      send_byte(8'h11); tick(4);
      send_byte(8'h22, 1'b0); tick(30);
      check("frame_pulse", n_frame - e0, 1);
      check("frame_novalid", n_valid - v0, 0);
      check("frame_idle", busy, 1'b0);
      send_byte(8'h02); tick(4);
      send_byte(8'h12); tick(4);
      send_byte(8'h34); tick(6);
      check("frame_recover", last_data[127:112], 16'h1234);
      check("frame_rec_len", last_len, 8'd2);

      // Inter-byte timeout
      v0 = n_valid;
      e0 = n_timeout;
      send_byte(8'h03); tick(4);
      n55 = cyc;
      send_byte(8'h55);
      tick(330);
      check("to_pulse", n_timeout - e0, 1);
      check("to_delay", to_seen - n55, 323);
      check("to_busy", busy, 1'b0);
      check("to_novalid", n_valid - v0, 0);

      // Backpressure and overrun
      rx_ready = 1'b0;
      v0 = n_valid;
      e0 = n_overrun;
      send_byte(8'h02); tick(4);
      send_byte(8'hC3); tick(4);
      send_byte(8'h3C); tick(4);
      send_byte(8'h01); tick(4);
      send_byte(8'h99); tick(6);
      check("bp_overruns", n_overrun - e0, 2);
      check("bp_count", n_valid - v0, 1);
      check("bp_held_valid", rx_valid, 1'b1);
      check("bp_held_data", rx_data[127:112], 16'hC33C);
      check("bp_held_low", rx_data[111:0], 112'd0);
      check("bp_held_len", rx_len, 8'd2);
      rx_ready = 1'b1;
      @(negedge clk);
      check("bp_before_edge", rx_valid, 1'b1);
      @(negedge clk);
      check("bp_released", rx_valid, 1'b0);
      @(posedge clk);
      #1;
      tick(4);

      // Reset in the middle of a packet
      v0 = n_valid;
      send_byte(8'h04); tick(4);
      send_byte(8'h01); tick(4);
      send_byte(8'h02); tick(2);
      resetn = 1'b0;
      tick(1);
      check("rst_valid", rx_valid, 1'b0);
      check("rst_data", rx_data, 128'd0);
      tick(2);
      resetn = 1'b1;
      tick(5);
      send_byte(8'h01); tick(4);
      send_byte(8'h5A); tick(6);
      check("rst_count", n_valid - v0, 1);
      check("rst_len", last_len, 8'd1);
      check("rst_data_after", last_data[127:120], 8'h5A);

      tick(5);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/comm_rx_packet.md
COMM_RX_PACKET -- requirements
Module: comm_rx_packet

Interface
REQ-001 Parameter CLK_HZ, default 50000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 115200, serial bit rate; DIVISOR = CLK_HZ/BAUD (integer division), and DIVISOR SHALL be at least 4.
REQ-003 Parameter MAX_BYTES, default 16, maximum payload bytes per packet, legal range 1..255.
REQ-004 Parameter TIMEOUT_BITS, default 32, maximum inter-byte gap within a packet, in bit periods.
REQ-005 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-006 clk  input  1  system clock; all logic on rising edge.
REQ-007 resetn  input  1  asynchronous active-low reset.
REQ-008 rx  input  1  UART line, idle high, asynchronous to clk.
REQ-009 rx_ready  input  1  consumer accepts the delivered packet.
REQ-010 rx_valid  output  1  packet available on rx_data/rx_len.
REQ-011 rx_data  output  8*MAX_BYTES  packet payload.
REQ-012 rx_len  output  8  payload byte count L.
REQ-013 busy  output  1  high in any state other than IDLE with the bit engine idle.
REQ-014 err_frame, err_len, err_timeout, err_overrun  output  1 each  one-cycle error pulses.

Function
REQ-015 rx SHALL pass through a two-flop synchroniser with reset value 1; all sampling SHALL use the synchronised value.
REQ-016 Bit engine states: B_IDLE, B_START, B_DATA, B_STOP.
- B_IDLE -> B_START on synchronised rx = 0.
- In B_START, rx is sampled after DIVISOR/2 cycles. If rx = 1, the start is false and the engine returns to B_IDLE. Otherwise -> B_DATA.
- In B_DATA, 8 bits are sampled LSB first, each DIVISOR cycles apart.
- In B_STOP, rx is sampled DIVISOR cycles after bit 7. If rx = 1, a byte strobe is produced. If rx = 0, err_frame pulses.
REQ-017 After a framing error the bit engine SHALL NOT re-arm until synchronised rx has been 1 for at least one full DIVISOR period.
REQ-018 Packet FSM states: IDLE, PAYLOAD, DELIVER.
- In IDLE, the first byte strobe is the length L.
- If L = 0 or L > MAX_BYTES, err_len pulses and the FSM stays in IDLE.
- Otherwise the byte counter is cleared, rx_data is cleared to 0, and the FSM goes to PAYLOAD.
REQ-019 In PAYLOAD, payload byte k (0-based) SHALL be written to rx_data[8*(MAX_BYTES-k)-1 -: 8]. The first byte lands in the most significant position; unused low bytes remain 0.
REQ-020 After byte L-1: rx_len <= L, rx_valid <= 1 on the clock edge following that byte's stop-bit sample, and the FSM goes to DELIVER.
REQ-021 rx_valid, rx_data and rx_len SHALL hold stable until a cycle with rx_valid = 1 and rx_ready = 1. That edge completes the transfer: rx_valid clears and the FSM returns to IDLE.
REQ-022 If rx_ready is already high in the first rx_valid cycle, the transfer SHALL complete in that same cycle.
REQ-023 Any byte strobe while in DELIVER SHALL pulse err_overrun and be discarded. rx_data, rx_len and rx_valid are unchanged.
REQ-024 Timeout counter:
- In PAYLOAD, the counter counts clk cycles and clears on each start-bit detection.
- Reaching TIMEOUT_BITS*DIVISOR pulses err_timeout, discards the partial packet and returns the FSM to IDLE.
- The counter is inactive in IDLE and DELIVER.
REQ-025 err_frame during PAYLOAD SHALL abort the packet and return the FSM to IDLE.
REQ-026 Error pulse rules:
- Each pulse lasts exactly one cycle.
- At most one error flag is asserted per cycle, with priority frame > len > timeout > overrun.
- A lower-priority error occurring in the same cycle is dropped.

Reset
REQ-027 While resetn = 0 the following SHALL hold:
- rx_valid = 0, rx_data = 0, rx_len = 0, busy = 0, all error flags = 0.
- Both FSMs are in B_IDLE/IDLE, all counters are 0, and the synchroniser flops are 1.
REQ-028 Reset asserted mid-byte or mid-packet SHALL discard all partial data. After release, the block waits for a fresh start bit.

Verification
All scenarios use CLK_HZ=50000000, BAUD=5000000 (DIVISOR=10), MAX_BYTES=16, TIMEOUT_BITS=32.
REQ-029 Nominal packet:
- Stimulus: send 04, 74, FB, 7B, FE with rx_ready held 1.
- Response: single-cycle rx_valid with rx_len=4, rx_data[127:96]=74FB7BFE, rx_data[95:0]=0, no error pulses.
REQ-030 Bad length:
- Stimulus: send 00, then 11 (17), then a valid 01, AB.
- Response: two err_len pulses and no rx_valid for the first two bytes; then rx_len=1, rx_data[127:120]=AB.
REQ-031 Framing error:
- Stimulus: send 03, 11, then 22 with stop bit driven 0, then line idle high.
- Response: one err_frame pulse, no rx_valid, FSM back in IDLE; a subsequent valid packet is received correctly.
REQ-032 Timeout:
- Stimulus: send 03, 55, then hold rx high for 330 clk.
- Response: err_timeout pulse at 320 cycles after the last start-bit detection, busy drops to 0, no rx_valid.
REQ-033 Backpressure:
- Stimulus: deliver packet 02 C3 3C with rx_ready=0, then send a further 01 99.
- Response: err_overrun for each of the two extra bytes; rx_data[127:112]=C33C and rx_len=2 held; raising rx_ready clears rx_valid on that edge.
REQ-034 Reset mid-packet:
- Stimulus: send 04, 01, 02, pulse resetn low for 3 clk, then send 01, 5A.
- Response: all outputs 0 during reset; after reset, rx_len=1 and rx_data[127:120]=5A.
